branch_controller: RTL and testbench

Resolves control flow for the Grizzly 16-bit core. It decodes the current fetched instruction and the latched ALU flags, then drives the `Branch` and `PCSet` inputs of the instruction fetcher. It holds a hardware return-address stack for CALL/RET. It sits between the fetcher's `PC`/`Instruction` outputs and its `Branch`/`PCSet` inputs, and closes the fetch loop.

---
 rtl/grizzly_pkg.sv | 20 ++
 rtl/branch_controller_return_stack.sv | 82 ++++++++
 rtl/branch_controller.sv | 133 +++++++++++++
 tb/tb_branch_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grizzly_pkg.sv
// Shared Grizzly core definitions: branch opcodes, address type, reset vector
// and the PC-relative target helper used by control-flow decode.
package grizzly_pkg;

   typedef logic [15:0] addr_t;

   localparam logic [3:0] OP_BZ   = 4'hA;
   localparam logic [3:0] OP_BN   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;

   localparam addr_t RESET_VECTOR = 16'h0000;

   // 12-bit signed offset added modulo 2^16, so targets wrap both ways.
   function automatic addr_t branch_target(input addr_t pc, input logic [11:0] off);
      return pc + {{4{off[11]}}, off};
   endfunction

endpackage

// File: rtl/branch_controller_return_stack.sv
// Circular hardware return-address stack: write pointer plus entry count.
// A push when full overwrites the oldest entry; a pop when empty returns zero.
module return_stack
   import grizzly_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     push,
   input  logic                     pop,
   input  addr_t                    din,
   output addr_t                    top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     unf
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

   addr_t         mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          full, empty;

   assign full   = (count_q == FULL_COUNT);
   assign empty  = (count_q == '0);
   assign rd_ptr = wr_ptr_q - 1'b1;

   assign top   = empty ? RESET_VECTOR : mem_q[rd_ptr];
   assign count = count_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (push) begin
         // When full the write pointer already sits on the oldest entry.
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            wr_ptr_d = rd_ptr;
            count_d  = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         if (push) begin
            mem_q[wr_ptr_q] <= din;
         end
      end
   end

endmodule

// File: rtl/branch_controller.sv
// Grizzly control-flow resolver: decodes branches against latched ALU flags and
// drives the fetcher redirect. Optional taken-branch counter via BRANCH_STATS_EN.
module branch_controller
   import grizzly_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  addr_t                    PC,
   input  logic [15:0]              Instruction,
   input  logic                     FlagsWe,
   input  logic                     ZeroIn,
   input  logic                     NegIn,
   output logic                     Branch,
   output addr_t                    PCSet,
   output logic [$clog2(DEPTH):0]   StackDepth,
   output logic                     Overflow,
   output logic                     Underflow
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]              TakenCount
`endif
);

   logic [3:0] opcode;
   addr_t      tgt;
   addr_t      ret_addr;
   addr_t      stack_top;
   logic       zero_q, zero_d;
   logic       neg_q, neg_d;
   logic       taken;
   addr_t      target;
   logic       push_dec, pop_dec;
   logic       push_en, pop_en;

   assign opcode   = Instruction[15:12];
   assign tgt      = branch_target(PC, Instruction[11:0]);
   assign ret_addr = PC + 16'd1;

   always_comb begin
      taken    = 1'b0;
      target   = '0;
      push_dec = 1'b0;
      pop_dec  = 1'b0;
      case (opcode)
         OP_BZ: begin
            taken  = zero_q;
            target = tgt;
         end
         OP_BN: begin
            taken  = neg_q;
            target = tgt;
         end
         OP_JMP: begin
            taken  = 1'b1;
            target = tgt;
         end
         OP_CALL: begin
            taken    = 1'b1;
            target   = tgt;
            push_dec = 1'b1;
         end
         OP_RET: begin
            taken   = 1'b1;
            target  = stack_top;
            pop_dec = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset drives the fetcher to the reset vector; its branch path outranks its own reset.
   assign Branch  = Reset | taken;
   assign PCSet   = Reset ? RESET_VECTOR : target;
   assign push_en = push_dec & ~Reset;
   assign pop_en  = pop_dec & ~Reset;

   always_comb begin
      zero_d = zero_q;
      neg_d  = neg_q;
      if (FlagsWe) begin
         zero_d = ZeroIn;
         neg_d  = NegIn;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         neg_q  <= neg_d;
      end
   end

   return_stack #(
      .DEPTH (DEPTH)
   ) u_return_stack (
      .Clock (Clock),
      .Reset (Reset),
      .push  (push_en),
      .pop   (pop_en),
      .din   (ret_addr),
      .top   (stack_top),
      .count (StackDepth),
      .ovf   (Overflow),
      .unf   (Underflow)
   );

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_q, taken_cnt_d;

   always_comb begin
      taken_cnt_d = taken_cnt_q;
      if (taken && (taken_cnt_q != 16'hFFFF)) begin
         taken_cnt_d = taken_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         taken_cnt_q <= '0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign TakenCount = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_controller.sv
// Self-checking bench for branch_controller: queue-based reference model, per-cycle
// compare, directed scenarios and randomized instruction stream.
module tb_branch_controller;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic [15:0]   PC = '0;
   logic [15:0]   Instruction = '0;
   logic          FlagsWe = 1'b0;
   logic          ZeroIn = 1'b0;
   logic          NegIn = 1'b0;
   logic          Branch;
   logic [15:0]   PCSet;
   logic [CW-1:0] StackDepth;
   logic          Overflow;
   logic          Underflow;
`ifdef BRANCH_STATS_EN
   logic [15:0]   TakenCount;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 Clock = ~Clock;

   branch_controller #(
      .DEPTH (DEPTH)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .PC          (PC),
      .Instruction (Instruction),
      .FlagsWe     (FlagsWe),
      .ZeroIn      (ZeroIn),
      .NegIn       (NegIn),
      .Branch      (Branch),
      .PCSet       (PCSet),
      .StackDepth  (StackDepth),
      .Overflow    (Overflow),
      .Underflow   (Underflow)
`ifdef BRANCH_STATS_EN
      ,
      .TakenCount  (TakenCount)
`endif
   );

   // Reference model state
   int  m_stack[$];
   bit  m_z, m_n, m_ovf, m_unf;
   int  m_taken;
   int  fetch_pc;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   function automatic void model_out(input int pc, input int instr, input bit rst,
                                     output bit br, output int ps);
      int op, off;
      op  = (instr / 4096) % 16;
      off = instr % 4096;
      if (off >= 2048) off = off - 4096;
      br = 1'b0;
      ps = 0;
      if (rst) begin
         br = 1'b1;
         return;
      end
      case (op)
         10: begin br = m_z; ps = (pc + off + 65536) % 65536; end
         11: begin br = m_n; ps = (pc + off + 65536) % 65536; end
         12, 13: begin br = 1'b1; ps = (pc + off + 65536) % 65536; end
         14: begin br = 1'b1; ps = (m_stack.size() > 0) ? m_stack[$] : 0; end
         default: ;
      endcase
   endfunction

   always @(posedge Clock) begin : model_upd
      bit br;
      int ps, op;
      model_out(int'(PC), int'(Instruction), Reset, br, ps);
      fetch_pc = br ? ps : (fetch_pc + 1) % 65536;
      op = int'(Instruction[15:12]);
      if (Reset) begin
         m_stack.delete();
         m_z = 0; m_n = 0; m_ovf = 0; m_unf = 0; m_taken = 0;
      end else begin
         if (br && m_taken < 65535) m_taken++;
         if (op == 13) begin
            m_stack.push_back((int'(PC) + 1) % 65536);
            if (m_stack.size() > DEPTH) begin
               void'(m_stack.pop_front());
               m_ovf = 1;
            end
         end else if (op == 14) begin
            if (m_stack.size() == 0) m_unf = 1;
            else void'(m_stack.pop_back());
         end
         if (FlagsWe) begin
            m_z = ZeroIn;
            m_n = NegIn;
         end
      end
   end

   always @(negedge Clock) begin : compare
      bit br;
      int ps;
      model_out(int'(PC), int'(Instruction), Reset, br, ps);
      chk("Branch", 32'(Branch), 32'(br));
      chk("PCSet", 32'(PCSet), 32'(ps));
      chk("StackDepth", 32'(StackDepth), 32'(m_stack.size()));
      chk("Overflow", 32'(Overflow), 32'(m_ovf));
      chk("Underflow", 32'(Underflow), 32'(m_unf));
`ifdef BRANCH_STATS_EN
      chk("TakenCount", 32'(TakenCount), 32'(m_taken));
`endif
   end

   task automatic drive(input logic [15:0] pc, input logic [15:0] instr,
                        input logic fwe = 1'b0, input logic z = 1'b0,
                        input logic n = 1'b0, input logic rst = 1'b0);
      PC = pc; Instruction = instr; FlagsWe = fwe; ZeroIn = z; NegIn = n; Reset = rst;
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [3:0] op;
      // Reset held two cycles
      drive(16'h0000, 16'h0000, 0, 0, 0, 1);
      @(negedge Clock);
      chk("rst_branch", 32'(Branch), 32'd1);
      chk("rst_pcset", 32'(PCSet), 32'h0);
      chk("rst_depth", 32'(StackDepth), 32'd0);
      tick;
      @(negedge Clock);
      chk("rst_branch2", 32'(Branch), 32'd1);
      tick;
      drive(16'(fetch_pc), 16'h0000);
      @(negedge Clock);
      chk("fetch_pc0", 32'(fetch_pc), 32'd0);
      tick;
      drive(16'(fetch_pc), 16'h0000);
      @(negedge Clock);
      chk("fetch_pc1", 32'(fetch_pc), 32'd1);
      tick;

      // JMP forward and backward
      drive(16'h0010, 16'hC0F0);
      @(negedge Clock);
      chk("jmp_fwd_br", 32'(Branch), 32'd1);
      chk("jmp_fwd_tgt", 32'(PCSet), 32'h0100);
      tick;
      drive(16'h0010, 16'hCFFF);
      @(negedge Clock);
      chk("jmp_back_tgt", 32'(PCSet), 32'h000F);
      tick;

      // Flags written this cycle are not yet visible
      drive(16'h0020, 16'hA004, 1, 1, 0);
      @(negedge Clock);
      chk("bz_old_flag", 32'(Branch), 32'd0);
      tick;
      drive(16'h0021, 16'hA004);
      @(negedge Clock);
      chk("bz_new_flag", 32'(Branch), 32'd1);
      chk("bz_tgt", 32'(PCSet), 32'h0025);
      tick;

      // CALL / RET pair
      drive(16'h0030, 16'hD010);
      @(negedge Clock);
      chk("call_tgt", 32'(PCSet), 32'h0040);
      tick;
      drive(16'h0040, 16'h0000);
      @(negedge Clock);
      chk("call_depth", 32'(StackDepth), 32'd1);
      tick;
      drive(16'h0041, 16'hE000);
      @(negedge Clock);
      chk("ret_tgt", 32'(PCSet), 32'h0031);
      tick;
      drive(16'h0031, 16'h0000);
      @(negedge Clock);
      chk("ret_depth", 32'(StackDepth), 32'd0);
      tick;

      // Overflow then drain to underflow
      for (int i = 1; i <= 9; i++) begin
         drive(16'(i), 16'hD000);
         tick;
      end
      drive(16'h0100, 16'h0000);
      @(negedge Clock);
      chk("ovf_flag", 32'(Overflow), 32'd1);
      chk("ovf_depth", 32'(StackDepth), 32'd8);
      tick;
      for (int k = 0; k < 8; k++) begin
         drive(16'h0100, 16'hE000);
         @(negedge Clock);
         chk("ret_order", 32'(PCSet), 32'(10 - k));
         tick;
      end
      drive(16'h0100, 16'hE000);
      @(negedge Clock);
      chk("unf_pcset", 32'(PCSet), 32'h0);
      tick;
      drive(16'h0100, 16'h0000);
      @(negedge Clock);
      chk("unf_flag", 32'(Underflow), 32'd1);
      tick;

      // Reset wins over a CALL in the same cycle
      drive(16'h0050, 16'hD010, 0, 0, 0, 1);
      @(negedge Clock);
      chk("rst_call_pcset", 32'(PCSet), 32'h0);
      tick;
      drive(16'h0000, 16'h0000);
      @(negedge Clock);
      chk("rst_call_depth", 32'(StackDepth), 32'd0);
      chk("rst_clears_ovf", 32'(Overflow), 32'd0);
      tick;

`ifdef BRANCH_STATS_EN
      drive(16'h0000, 16'h0000, 0, 0, 0, 1);
      tick;
      for (int i = 0; i < 5; i++) begin
         drive(16'(i), 16'hC001);
         tick;
      end
      for (int i = 0; i < 3; i++) begin
         drive(16'(i), 16'h1234);
         tick;
      end
      @(negedge Clock);
      chk("stats_count", 32'(TakenCount), 32'd5);
      tick;
      drive(16'h0000, 16'h0000, 0, 0, 0, 1);
      tick;
      @(negedge Clock);
      chk("stats_reset", 32'(TakenCount), 32'd0);
      tick;
`endif

      // Randomized stream, biased toward control-flow opcodes
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
         else op = 4'($urandom_range(10, 14));
         drive(16'($urandom), {op, 12'($urandom)}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 99) == 0));
         tick;
      end
      drive(16'h0000, 16'h0000);
      tick;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
